mult4b_seq: RTL
===============

Name: mult4b_seq

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier built around the team's 4-bit ripple adder `sum4b`.
- Drives the adder's A/B operands each cycle and registers its So/Co results; it is the stage directly upstream and downstream of the adder.
- Produces an 8-bit product after a fixed 4-iteration pass.
- Uses a start/busy/done handshake. Serves as the next lab stage after the combinational adder.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal because the adder datapath is fixed at 4 bits; elaboration-time check errors on any other value.
- CNT_W, 2, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  4  multiplicand; captured on accepted start.
- B  input  4  multiplier; captured on accepted start.
- busy  output  1  high while in CALC or DONE.
- done  output  1  single-cycle pulse: product valid.
- P  output  8  product {acc_hi, q}; holds value until next accepted start.

Behaviour:
- Reset (async assert, sync deassert by design intent): state=IDLE, M=0, acc_hi=0, q=0, cnt=0, busy=0, done=0, P=0.
- Registers:
  - M[3:0] multiplicand.
  - acc_hi[3:0] upper product half.
  - q[3:0] multiplier/lower product half.
  - cnt[1:0] iteration counter.
- Datapath: the `sum4b` instance gets A=acc_hi and B=M, so the add is combinational. Here `{Co,So}` = acc_hi + M.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at a rising edge: M<=A, q<=B, acc_hi<=0, cnt<=0, go to CALC.
  - Otherwise hold all registers; P keeps its last product.
- CALC, one iteration per edge:
  - If q[0]=1: {acc_hi,q} <= {Co,So,q[3:1]}, i.e. a 9-bit right shift of {Co,So,q}.
  - If q[0]=0: {acc_hi,q} <= {1'b0,acc_hi,q[3:1]}.
  - cnt<=cnt+1. When cnt==3 at the edge, go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Outputs are decoded from registered state, so there are no combinational paths from inputs to outputs:
  - busy=1 in CALC and DONE.
  - P={acc_hi,q}.
- Latency: start accepted at edge k → CALC edges k+1..k+4 → done high in the cycle between edges k+4 and k+5. Total 5 cycles from start to done.
- P may show partial values while busy=1. It is valid and stable from done=1 until the edge that accepts the next start.
- start while busy=1 (CALC or DONE) is ignored, with no queuing. start on the cycle after done, back in IDLE, is accepted.
- A/B changes after acceptance do not affect the result.
- Carry out of the final add is never lost; 15*15=225 fits in 8 bits.
- rst_n low mid-operation: immediate return to reset values. done never pulses for the aborted operation.

Decomposition:
- Shared include file holds the FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the WIDTH constant.
- One sub-module: the existing `sum4b`, instantiated once.
- Control FSM and shift registers live in mult4b_seq itself; no further sub-modules.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release, no start → P=0x00, busy=0, done=0 for 10 cycles.
- A=15, B=15, start 1 cycle → busy next cycle, done exactly 5 cycles after start edge, P=0xE1 (225); P holds 0xE1 for 5 more idle cycles.
- A=12, B=10 → P=0x78 (120). Then A=0, B=9 → P=0x00. Then A=1, B=9 → P=0x09.
- Start held high continuously with A=3, B=5, changing A/B to 7/7 mid-op → first result P=0x0F, done pulses one cycle. Next operation starts the cycle after done and yields 0x31.
- Reset mid-op: start A=9, B=9, assert rst_n at CALC cycle 2 → P=0, busy=0 immediately; no done pulse. A fresh start afterwards gives P=0x51.
- Exhaustive: all 256 A/B pairs back-to-back, each checked against A*B at done. Also check done width=1 and busy=1 for exactly 5 cycles per operation.

Source files
------------

// File: rtl/mult4b_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential 4x4 multiplier.
package mult4b_seq_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum4b.sv
// 4-bit ripple-carry adder: {Co,So} = A + B.
module sum4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] So,
    output logic       Co
);

    logic [4:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign So[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Co = c[4];

endmodule

// File: rtl/mult4b_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier around the sum4b ripple adder,
// with a start/busy/done handshake and a fixed 4-iteration pass.
module mult4b_seq
    import mult4b_seq_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    if (WIDTH != 4) begin : g_bad_width
        $error("mult4b_seq: WIDTH must be 4, the sum4b datapath is fixed at 4 bits");
    end

    state_t           state;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] so;
    logic             co;
    logic [2*WIDTH:0] step;

    sum4b u_sum4b (
        .A  (acc_hi),
        .B  (m),
        .So (so),
        .Co (co)
    );

    // Either the sum with its carry or the bare accumulator, then one right shift.
    assign step = q[0] ? {co, so, q} : {1'b0, acc_hi, q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            m      <= '0;
            acc_hi <= '0;
            q      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m      <= A;
                        q      <= B;
                        acc_hi <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    {acc_hi, q} <= step[2*WIDTH:1];
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign P = {acc_hi, q};

endmodule
